// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, load/store and RAM port bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 12
);
  logic              if_req;
  logic [WIDTH-1:0]  if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [WIDTH-1:0]  if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [WIDTH-1:0]  ls_addr;
  logic [WIDTH-1:0]  ls_wdata;
  logic [2:0]        ls_funct3;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [WIDTH-1:0]  ls_rdata;
  logic              ls_err;

  logic [ADDR_W-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_data;
  logic              ram_wren;
  logic [WIDTH-1:0]  ram_q;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_funct3, ram_q,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err,
           ram_addr, ram_data, ram_wren
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_funct3, ram_q,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err,
           ram_addr, ram_data, ram_wren
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/LSU arbiter and access sequencer for a single-port RAM
// Sub-word stores use read-modify-write; loads are lane-extracted and extended by funct3.
module mem_arbiter #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 12
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RD_RESP   = 3'd1;
  localparam logic [2:0] S_RMW_MERGE = 3'd2;
  localparam logic [2:0] S_WR_ACK    = 3'd3;
  localparam logic [2:0] S_ERR_RESP  = 3'd4;

  logic [2:0]        state;
  logic              rr_last;   // 1: last grant went to the LSU
  logic              side_ls;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        byte_q;
  logic [2:0]        f3_q;
  logic [15:0]       wdata_q;

  logic              idle;
  logic              grant_if;
  logic              grant_ls;
  logic              ls_bad;
  logic              ls_sw;
  logic [WIDTH-1:0]  merged;
  logic [WIDTH-1:0]  load_data;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic              unused_bits;

  assign unused_bits = ^{bus.if_addr[WIDTH-1:ADDR_W+2], bus.if_addr[1:0],
                         bus.ls_addr[WIDTH-1:ADDR_W+2]};

  // Grants are combinational, so rst gates them to keep every output low in reset.
  assign idle     = (state == S_IDLE) && rst;
  assign grant_if = idle && bus.if_req && (!bus.ls_req || rr_last);
  assign grant_ls = idle && bus.ls_req && (!bus.if_req || !rr_last);
  assign ls_sw    = bus.ls_we && (bus.ls_funct3 == 3'b010) && !ls_bad;

  always_comb begin
    ls_bad = 1'b1;
    case (bus.ls_funct3)
      3'b000:  ls_bad = 1'b0;
      3'b001:  ls_bad = bus.ls_addr[0];
      3'b010:  ls_bad = |bus.ls_addr[1:0];
      3'b100:  ls_bad = bus.ls_we;
      3'b101:  ls_bad = bus.ls_we | bus.ls_addr[0];
      default: ls_bad = 1'b1;
    endcase
  end

  assign lane_b = bus.ram_q[{byte_q, 3'b000} +: 8];
  assign lane_h = bus.ram_q[{byte_q[1], 4'b0000} +: 16];

  always_comb begin
    merged = bus.ram_q;
    if (f3_q[0]) merged[{byte_q[1], 4'b0000} +: 16] = wdata_q;
    else         merged[{byte_q, 3'b000} +: 8]      = wdata_q[7:0];
  end

  always_comb begin
    case (f3_q)
      3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_data = {24'd0, lane_b};
      3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_data = {16'd0, lane_h};
      default: load_data = bus.ram_q;
    endcase
  end

  always_comb begin
    bus.if_gnt    = grant_if;
    bus.ls_gnt    = grant_ls;
    bus.if_rvalid = 1'b0;
    bus.if_rdata  = '0;
    bus.ls_rvalid = 1'b0;
    bus.ls_rdata  = '0;
    bus.ls_err    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_data  = '0;
    bus.ram_wren  = 1'b0;
    if (grant_if)                bus.ram_addr = bus.if_addr[ADDR_W+1:2];
    else if (grant_ls && !ls_bad) bus.ram_addr = bus.ls_addr[ADDR_W+1:2];
    else if (state != S_IDLE)    bus.ram_addr = addr_q;
    if (grant_ls && ls_sw) begin
      bus.ram_wren = 1'b1;
      bus.ram_data = bus.ls_wdata;
    end
    case (state)
      S_RD_RESP: begin
        if (side_ls) begin
          bus.ls_rvalid = 1'b1;
          bus.ls_rdata  = load_data;
        end else begin
          bus.if_rvalid = 1'b1;
          bus.if_rdata  = bus.ram_q;
        end
      end
      S_RMW_MERGE: begin
        bus.ram_wren = 1'b1;
        bus.ram_data = merged;
      end
      S_WR_ACK:   bus.ls_rvalid = 1'b1;
      S_ERR_RESP: begin
        bus.ls_rvalid = 1'b1;
        bus.ls_err    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      rr_last <= 1'b0;
      side_ls <= 1'b0;
      addr_q  <= '0;
      byte_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_if) begin
            rr_last <= 1'b0;
            side_ls <= 1'b0;
            addr_q  <= bus.if_addr[ADDR_W+1:2];
            state   <= S_RD_RESP;
          end else if (grant_ls) begin
            rr_last <= 1'b1;
            side_ls <= 1'b1;
            byte_q  <= bus.ls_addr[1:0];
            f3_q    <= bus.ls_funct3;
            wdata_q <= bus.ls_wdata[15:0];
            if (ls_bad) begin
              addr_q <= '0;
              state  <= S_ERR_RESP;
            end else begin
              addr_q <= bus.ls_addr[ADDR_W+1:2];
              if (!bus.ls_we) state <= S_RD_RESP;
              else if (ls_sw) state <= S_WR_ACK;
              else            state <= S_RMW_MERGE;
            end
          end
        end
        S_RMW_MERGE: state <= S_WR_ACK;
        default:     state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a RAM model and reference model
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.WIDTH(32), .ADDR_W(12)) bus ();
  mem_arbiter #(.WIDTH(32), .ADDR_W(12)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] ram  [0:4095];
  logic [31:0] gold [0:4095];
  logic        pre_we;
  logic [11:0] pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (pre_we)            ram[pre_addr]     <= pre_data;
    else if (bus.ram_wren) ram[bus.ram_addr] <= bus.ram_data;
    bus.ram_q <= ram[bus.ram_addr];
  end

  int checks = 0;
  int errors = 0;
  bit last_ls = 1'b0;

  task automatic preload(input int idx, input logic [31:0] v);
    pre_addr = idx[11:0];
    pre_data = v;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
    gold[idx] = v;
  endtask

  // Expected response derived from the access rules on a word-array memory.
  task automatic model_ls(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, output logic e_err, output logic [31:0] e_rd,
                          output int e_lat, output int e_wcyc);
    int sz, off, idx;
    logic [31:0] w, sh, mask;
    sz  = int'(f3[1:0]);
    off = int'(addr % 4);
    idx = int'((addr / 4) % 4096);
    w   = gold[idx];
    e_err = (sz == 3) || (f3 >= 3'd6) || (we && f3[2]) ||
            (sz == 1 && (off % 2) != 0) || (sz == 2 && off != 0);
    e_rd = 32'd0; e_lat = 1; e_wcyc = -1;
    if (!e_err) begin
      if (!we) begin
        sh = w >> (8 * off);
        if (sz == 0) begin
          e_rd = sh & 32'hff;
          if (!f3[2] && e_rd[7]) e_rd = e_rd | 32'hffffff00;
        end else if (sz == 1) begin
          e_rd = sh & 32'hffff;
          if (!f3[2] && e_rd[15]) e_rd = e_rd | 32'hffff0000;
        end else e_rd = w;
      end else begin
        mask = (sz == 0) ? 32'hff : (sz == 1) ? 32'hffff : 32'hffffffff;
        gold[idx] = (w & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
        e_wcyc = (sz == 2) ? 0 : 1;
        e_lat  = (sz == 2) ? 1 : 2;
      end
    end
  endtask

  task automatic ls_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, input string name);
    logic e_err, er;
    logic [31:0] e_rd, rd;
    int e_lat, e_wcyc, wcnt, wcyc, lat;
    bit got;
    model_ls(we, addr, wdata, f3, e_err, e_rd, e_lat, e_wcyc);
    bus.ls_req = 1'b1; bus.ls_we = we; bus.ls_addr = addr;
    bus.ls_wdata = wdata; bus.ls_funct3 = f3;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (bus.ls_gnt) begin got = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s grant: no ls_gnt within 20 cycles", name);
      bus.ls_req = 1'b0;
    end else begin
      last_ls = 1'b1;
      wcnt = bus.ram_wren ? 1 : 0;
      wcyc = bus.ram_wren ? 0 : -1;
      lat = -1; rd = 32'd0; er = 1'b0;
      @(negedge clk);
      bus.ls_req = 1'b0;
      for (int k = 1; k <= 5; k++) begin
        #2;
        if (bus.ram_wren) begin wcnt++; if (wcyc < 0) wcyc = k; end
        if (bus.ls_rvalid) begin lat = k; rd = bus.ls_rdata; er = bus.ls_err; break; end
        @(negedge clk);
      end
      @(negedge clk);
      checks += 5;
      if (lat != e_lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, e_lat); end
      if (er !== e_err) begin errors++; $display("FAIL %s ls_err: got %b expected %b", name, er, e_err); end
      if (rd !== e_rd) begin errors++; $display("FAIL %s ls_rdata: got %h expected %h", name, rd, e_rd); end
      if (wcnt != ((e_wcyc >= 0) ? 1 : 0)) begin
        errors++; $display("FAIL %s wren count: got %0d expected %0d", name, wcnt, (e_wcyc >= 0) ? 1 : 0);
      end
      if (wcyc != e_wcyc) begin errors++; $display("FAIL %s wren cycle: got %0d expected %0d", name, wcyc, e_wcyc); end
    end
  endtask

  task automatic if_op(input logic [31:0] addr);
    bit got;
    logic [31:0] exp;
    exp = gold[int'((addr / 4) % 4096)];
    bus.if_req = 1'b1; bus.if_addr = addr;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (bus.if_gnt) begin got = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL fetch grant: no if_gnt within 20 cycles");
      bus.if_req = 1'b0;
    end else begin
      last_ls = 1'b0;
      @(negedge clk);
      bus.if_req = 1'b0;
      #2;
      checks++;
      if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== exp) begin
        errors++;
        $display("FAIL fetch %h: rvalid %b rdata %h expected rvalid 1 rdata %h", addr, bus.if_rvalid, bus.if_rdata, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    bus.if_req = 1'b1; bus.if_addr = 32'h44;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_funct3 = 3'b010;
    bus.ls_addr = 32'h40; bus.ls_wdata = 32'hCAFEF00D;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if ({bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid, bus.ls_err, bus.ram_wren} !== 6'd0 ||
        bus.ram_addr !== 12'd0 || bus.ram_data !== 32'd0 || bus.if_rdata !== 32'd0 || bus.ls_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset outputs: gnt %b%b rv %b%b err %b wren %b addr %h data %h rd %h/%h expected all 0",
               bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid, bus.ls_err, bus.ram_wren,
               bus.ram_addr, bus.ram_data, bus.if_rdata, bus.ls_rdata);
    end
    @(negedge clk);
    rst = 1'b1;
    #2;
    checks++;
    if (bus.ls_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin
      errors++; $display("FAIL first grant: ls_gnt %b if_gnt %b expected 1 0", bus.ls_gnt, bus.if_gnt);
    end
    gold[16] = 32'hCAFEF00D;
    last_ls = 1'b1;
    @(negedge clk);
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ram[16] !== 32'hCAFEF00D) begin errors++; $display("FAIL reset first store: got %h expected cafef00d", ram[16]); end
  endtask

  task automatic test_directed;
    preload(1, 32'h8899AABB);
    preload(2, 32'h11223344);
    ls_op(1'b0, 32'h5, 32'h0, 3'b000, "lb_0x5");
    ls_op(1'b0, 32'h5, 32'h0, 3'b100, "lbu_0x5");
    ls_op(1'b0, 32'h6, 32'h0, 3'b001, "lh_0x6");
    ls_op(1'b1, 32'hA, 32'hEE, 3'b000, "sb_0xa");
    checks++;
    if (ram[2] !== 32'h11EE3344) begin errors++; $display("FAIL sb_0xa ram: got %h expected 11ee3344", ram[2]); end
    ls_op(1'b0, 32'h2, 32'h0, 3'b010, "lw_0x2_err");
    ls_op(1'b1, 32'h3, 32'hBEEF, 3'b001, "sh_0x3_err");
    ls_op(1'b1, 32'h4, 32'h1234, 3'b011, "f3_011_err");
    ls_op(1'b1, 32'h8, 32'h55, 3'b100, "sbu_err");
    checks++;
    if (ram[0] !== gold[0] || ram[1] !== gold[1] || ram[2] !== gold[2]) begin
      errors++; $display("FAIL error ram unchanged: got %h %h %h expected %h %h %h",
                         ram[0], ram[1], ram[2], gold[0], gold[1], gold[2]);
    end
    if_op(32'h7);
  endtask

  task automatic test_round_robin;
    int ngnt, last_c;
    bit prev_ls;
    ngnt = 0; last_c = -1; prev_ls = last_ls;
    bus.if_addr = 32'h8; bus.ls_we = 1'b0; bus.ls_funct3 = 3'b010; bus.ls_addr = 32'h4;
    bus.if_req = 1'b1; bus.ls_req = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #2;
      if (bus.if_gnt || bus.ls_gnt) begin
        checks++;
        if (bus.if_gnt === bus.ls_gnt || bus.ls_gnt !== !prev_ls) begin
          errors++; $display("FAIL rr side cycle %0d: ls_gnt %b if_gnt %b expected ls_gnt %b", c, bus.ls_gnt, bus.if_gnt, !prev_ls);
        end
        if (last_c >= 0) begin
          checks++;
          if (c - last_c != 2) begin errors++; $display("FAIL rr spacing: got %0d expected 2", c - last_c); end
        end
        prev_ls = bus.ls_gnt; last_c = c; ngnt++;
      end
      if (bus.if_rvalid) begin
        checks++;
        if (bus.if_rdata !== gold[2]) begin errors++; $display("FAIL rr if_rdata: got %h expected %h", bus.if_rdata, gold[2]); end
      end
      if (bus.ls_rvalid) begin
        checks++;
        if (bus.ls_rdata !== gold[1]) begin errors++; $display("FAIL rr ls_rdata: got %h expected %h", bus.ls_rdata, gold[1]); end
      end
      @(negedge clk);
    end
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    last_ls = prev_ls;
    checks++;
    if (ngnt != 8) begin errors++; $display("FAIL rr grant count: got %0d expected 8", ngnt); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) if_op($urandom_range(0, 127));
      else ls_op(1'($urandom_range(0, 1)), $urandom_range(0, 127), $urandom,
                 3'($urandom_range(0, 7)), "random");
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (ram[i] !== gold[i]) begin errors++; $display("FAIL random ram[%0d]: got %h expected %h", i, ram[i], gold[i]); end
    end
  endtask

  task automatic test_reset_mid_rmw;
    bit got;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h10;
    bus.ls_wdata = 32'h1234; bus.ls_funct3 = 3'b001;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (bus.ls_gnt) begin got = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!got) begin errors++; $display("FAIL rmw reset grant: no ls_gnt within 20 cycles"); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.ls_req = 1'b0;
    #1;
    checks++;
    if (bus.ram_wren !== 1'b0 || bus.ls_rvalid !== 1'b0) begin
      errors++; $display("FAIL rmw reset outputs: wren %b rvalid %b expected 0 0", bus.ram_wren, bus.ls_rvalid);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    last_ls = 1'b0;
    checks++;
    if (ram[4] !== gold[4]) begin errors++; $display("FAIL rmw reset ram: got %h expected %h", ram[4], gold[4]); end
    ls_op(1'b0, 32'h10, 32'h0, 3'b010, "lw_after_reset");
  endtask

  initial begin
    rst = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.ls_req = 1'b0; bus.ls_we = 1'b0;
    bus.ls_addr = '0; bus.ls_wdata = '0; bus.ls_funct3 = '0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) preload(i, $urandom);
    test_reset;
    test_directed;
    test_round_robin;
    test_random;
    test_reset_mid_rmw;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
